// File: rtl/register_file_pkg.sv
// ---------------------------------------------------------------------------
// cpu_defs : shared datapath definitions for the register file.
//
// Contents:
//   REG_ADDR_W  - register address width (5)
//   REG_DATA_W  - register / data-port width (32)
//   REG_COUNT   - number of architectural registers (32)
//   REG_ZERO    - address of the hardwired-zero register
//   reg_addr_t  - register address type
//   reg_data_t  - register data type
//   reg_count() - register count for a given address width
// ---------------------------------------------------------------------------
package cpu_defs;

  localparam int REG_ADDR_W = 5;
  localparam int REG_DATA_W = 32;
  localparam int REG_COUNT  = 32;

  localparam logic [REG_ADDR_W-1:0] REG_ZERO = 5'd0;

  typedef logic [REG_ADDR_W-1:0] reg_addr_t;
  typedef logic [REG_DATA_W-1:0] reg_data_t;

  // Register count implied by an address width; keeps the decoder and the
  // storage array sized from the same expression.
  function automatic int reg_count(input int addr_w);
    return 1 << addr_w;
  endfunction

endpackage

// File: rtl/register_file_decoder.sv
// ---------------------------------------------------------------------------
// WriteAddrDecoder5To32 : write-address decoder for the register file.
//
// Turns the destination address from the RegDst selector into a one-hot
// register write-enable vector. Bit 0 is tied low so the zero register can
// never be selected, whatever WriteAddr and WriteEnable are.
//
// Parameters:
//   ADDR_W       - address width (enable vector is 2**ADDR_W bits)
// Ports:
//   WriteAddr    in   ADDR_W bits  destination register address
//   WriteEnable  in   1 bit        RegWrite from the control unit
//   WriteSelect  out  2**ADDR_W    one-hot write enable, bit 0 always 0
// ---------------------------------------------------------------------------
module WriteAddrDecoder5To32
  import cpu_defs::*;
#(
  parameter int ADDR_W = REG_ADDR_W
) (
  input  logic [ADDR_W-1:0]           WriteAddr,
  input  logic                        WriteEnable,
  output logic [(1 << ADDR_W)-1:0]    WriteSelect
);

  localparam int COUNT = reg_count(ADDR_W);

  genvar gi;
  generate
    for (gi = 0; gi < COUNT; gi++) begin : g_sel
      if (gi == 0) begin : g_zero
        // The zero register is read-only.
        assign WriteSelect[gi] = 1'b0;
      end else begin : g_decode
        assign WriteSelect[gi] = WriteEnable && (WriteAddr == ADDR_W'(gi));
      end
    end
  endgenerate

endmodule

// File: rtl/register_file.sv
// ---------------------------------------------------------------------------
// register_file : two-read, one-write general-purpose register file for the
// multicycle CPU datapath. Register 0 is hardwired to zero.
//
// Build option:
//   REGFILE_WRITE_BYPASS_EN - when defined, a read port whose address matches
//   an active (non-zero) write returns WriteData in the same cycle. When not
//   defined, reads always return the stored contents.
//
// Parameters:
//   DATA_W       - register and data-port width
//   ADDR_W       - address width; 2**ADDR_W registers
// Ports:
//   CLK          in   1 bit    rising-edge clock
//   RST          in   1 bit    asynchronous, active-low reset
//   ReadAddrA    in   ADDR_W   read port A address (rs)
//   ReadAddrB    in   ADDR_W   read port B address (rt)
//   WriteAddr    in   ADDR_W   destination address (RegDst selector)
//   WriteData    in   DATA_W   write-back data
//   WriteEnable  in   1 bit    RegWrite
//   ReadDataA    out  DATA_W   contents at ReadAddrA (combinational)
//   ReadDataB    out  DATA_W   contents at ReadAddrB (combinational)
// ---------------------------------------------------------------------------
module register_file
  import cpu_defs::*;
#(
  parameter int DATA_W = REG_DATA_W,
  parameter int ADDR_W = REG_ADDR_W
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic [ADDR_W-1:0] ReadAddrA,
  input  logic [ADDR_W-1:0] ReadAddrB,
  input  logic [ADDR_W-1:0] WriteAddr,
  input  logic [DATA_W-1:0] WriteData,
  input  logic              WriteEnable,
  output logic [DATA_W-1:0] ReadDataA,
  output logic [DATA_W-1:0] ReadDataB
);

  localparam int COUNT = reg_count(ADDR_W);

  logic [COUNT-1:0]  write_sel;
  logic [DATA_W-1:0] regs_view [COUNT];
  logic [DATA_W-1:0] stored_a;
  logic [DATA_W-1:0] stored_b;

  WriteAddrDecoder5To32 #(
    .ADDR_W      (ADDR_W)
  ) u_decoder (
    .WriteAddr   (WriteAddr),
    .WriteEnable (WriteEnable),
    .WriteSelect (write_sel)
  );

  // Storage: one register per entry, each enabled by its own decoder bit.
  // The reset is asynchronous so the outputs drop to zero as soon as RST
  // goes low; an edge that sees RST low clears instead of writing, which is
  // what drops a write coinciding with reset release.
  genvar gi;
  generate
    for (gi = 0; gi < COUNT; gi++) begin : g_reg
      if (gi == 0) begin : g_zero
        assign regs_view[gi] = '0;
      end else begin : g_entry
        logic [DATA_W-1:0] q_reg;

        always_ff @(posedge CLK or negedge RST) begin
          if (!RST) begin
            q_reg <= '0;
          end else if (write_sel[gi]) begin
            q_reg <= WriteData;
          end
        end

        assign regs_view[gi] = q_reg;
      end
    end
  endgenerate

  // Read multiplexers: purely combinational from address to data.
  assign stored_a = regs_view[ReadAddrA];
  assign stored_b = regs_view[ReadAddrB];

`ifdef REGFILE_WRITE_BYPASS_EN
  // The decoder output already excludes address 0 and an idle write port, so
  // indexing it with the read address is exactly the forwarding condition.
  // Forwarding is suppressed during reset so both ports read zero then.
  logic fwd_a;
  logic fwd_b;

  assign fwd_a = RST && write_sel[ReadAddrA];
  assign fwd_b = RST && write_sel[ReadAddrB];

  assign ReadDataA = fwd_a ? WriteData : stored_a;
  assign ReadDataB = fwd_b ? WriteData : stored_b;
`else
  assign ReadDataA = stored_a;
  assign ReadDataB = stored_b;
`endif

endmodule
